// File: rtl/fsmc_interface.sv
// fsmc_interface: MCU FSMC multiplexed-bus slave bridge into the fabric clock domain
module fsmc_interface (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        NADV,
    input  logic        NWE,
    input  logic        NOE,
    inout  wire  [17:0] AD,
    output logic [15:0] rd_data,
    input  logic [31:0] wr_data,
    output logic [3:0]  cs,
    output logic        addr_en,
    output logic        rd_en,
    output logic        wr_en
);
    typedef enum logic [1:0] {IDLE, ADDR, WRITE, READ} state_t;

    state_t      state_q, state_d;
    logic [2:0]  nadv_q, nwe_q, noe_q;
    logic [17:0] ad1_q, ad2_q;
    logic [17:0] addr_q, addr_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic [3:0]  cs_q, cs_d;
    logic        addr_en_q, addr_en_d;
    logic        rd_en_q, rd_en_d;
    logic        wr_en_q, wr_en_d;
    logic        oe_q, oe_d;
    logic        nadv_rise, nwe_fall, nwe_rise, noe_fall, noe_rise;
    logic        unused;

    // Bit 1 of each strobe shift register is the synchronised level, bit 2 its history
    assign nadv_rise = nadv_q[1] & ~nadv_q[2];
    assign nwe_fall  = ~nwe_q[1] & nwe_q[2];
    assign nwe_rise  = nwe_q[1] & ~nwe_q[2];
    assign noe_fall  = ~noe_q[1] & noe_q[2];
    assign noe_rise  = noe_q[1] & ~noe_q[2];

    // Strobe synchronisers and matching two-stage AD delay so data lines up with detected edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nadv_q <= 3'b111;
            nwe_q  <= 3'b111;
            noe_q  <= 3'b111;
            ad1_q  <= '0;
            ad2_q  <= '0;
        end else begin
            nadv_q <= {nadv_q[1:0], NADV};
            nwe_q  <= {nwe_q[1:0], NWE};
            noe_q  <= {noe_q[1:0], NOE};
            ad1_q  <= AD;
            ad2_q  <= ad1_q;
        end
    end

    // Bus-phase FSM next state, latched values and single-cycle enable pulses
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cs_d      = cs_q;
        rd_data_d = rd_data_q;
        addr_en_d = 1'b0;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!nadv_q[1]) begin
                    state_d = ADDR;
                end else if (nwe_fall) begin
                    state_d = WRITE;
                end else if (noe_fall) begin
                    state_d = READ;
                    rd_en_d = 1'b1;
                end
            end
            ADDR: begin
                if (nadv_rise) begin
                    state_d   = IDLE;
                    addr_d    = ad2_q;
                    cs_d      = ad2_q[3:0];
                    addr_en_d = 1'b1;
                end
            end
            WRITE: begin
                if (nwe_rise) begin
                    state_d   = IDLE;
                    rd_data_d = ad2_q[15:0];
                    wr_en_d   = 1'b1;
                end
            end
            READ: state_d = noe_rise ? IDLE : READ;
            default: state_d = IDLE;
        endcase
        oe_d = state_d == READ;
    end

    // Register FSM state and all outputs so nothing downstream sees combinational glitches
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cs_q      <= '0;
            rd_data_q <= '0;
            addr_en_q <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cs_q      <= cs_d;
            rd_data_q <= rd_data_d;
            addr_en_q <= addr_en_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            oe_q      <= oe_d;
        end
    end

    // Never drive while the MCU may be presenting an address
    assign AD      = (oe_q && nadv_q[1]) ? wr_data[17:0] : 18'bz;
    assign rd_data = rd_data_q;
    assign cs      = cs_q;
    assign addr_en = addr_en_q;
    assign rd_en   = rd_en_q;
    assign wr_en   = wr_en_q;

    assign unused = ^{addr_q, wr_data[31:18]};
endmodule

// File: tb/tb_fsmc_interface.sv
// tb_fsmc_interface: directed self-checking bench for the FSMC bridge
module tb_fsmc_interface;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        NADV = 1'b1;
    logic        NWE = 1'b1;
    logic        NOE = 1'b1;
    logic [31:0] wr_data = '0;
    logic [15:0] rd_data;
    logic [3:0]  cs;
    logic        addr_en, rd_en, wr_en;
    logic        mcu_oe = 1'b0;
    logic [17:0] mcu_ad = '0;
    wire  [17:0] AD;

    int n_checks = 0;
    int n_fail = 0;
    int addr_cnt = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic [15:0] wr_snap = '0;
    int base_a, base_r, base_w;

    localparam logic [17:0] HIZ = 18'h3FFFF;

    assign AD = mcu_oe ? mcu_ad : 18'bz;
    for (genvar i = 0; i < 18; i++) begin : g_pu
        pullup (AD[i]);
    end

    always #5 clk = ~clk;

    fsmc_interface dut (
        .clk     (clk),
        .reset_n (reset_n),
        .NADV    (NADV),
        .NWE     (NWE),
        .NOE     (NOE),
        .AD      (AD),
        .rd_data (rd_data),
        .wr_data (wr_data),
        .cs      (cs),
        .addr_en (addr_en),
        .rd_en   (rd_en),
        .wr_en   (wr_en)
    );

    // Count high cycles of each pulse and capture rd_data in the cycle wr_en is high
    always @(negedge clk) begin
        if (addr_en) addr_cnt++;
        if (rd_en) rd_cnt++;
        if (wr_en) begin
            wr_cnt++;
            wr_snap = rd_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        base_a = addr_cnt;
        base_r = rd_cnt;
        base_w = wr_cnt;
    endtask

    task automatic mcu_addr(input logic [17:0] a);
        mcu_ad = a;
        mcu_oe = 1'b1;
        NADV = 1'b0;
        tick(5);
        NADV = 1'b1;
        tick(4);
        mcu_oe = 1'b0;
        tick(2);
    endtask

    task automatic mcu_write(input logic [17:0] d);
        mcu_ad = d;
        mcu_oe = 1'b1;
        NWE = 1'b0;
        tick(16);
        NWE = 1'b1;
        tick(4);
        mcu_oe = 1'b0;
        tick(2);
    endtask

    task automatic mcu_read(input logic [17:0] exp, input string tag);
        NOE = 1'b0;
        tick(5);
        check({tag, "_driven"}, {14'd0, AD}, {14'd0, exp});
        tick(3);
        NOE = 1'b1;
        tick(1);
        check({tag, "_hold"}, {14'd0, AD}, {14'd0, exp});
        tick(3);
        check({tag, "_release"}, {14'd0, AD}, {14'd0, HIZ});
        tick(2);
    endtask

    initial begin
        tick(3);
        check("in_reset_ad", {14'd0, AD}, {14'd0, HIZ});
        reset_n = 1'b1;
        tick(3);
        check("rst_rd_data", {16'd0, rd_data}, 32'h0);
        check("rst_cs", {28'd0, cs}, 32'h0);
        check("rst_enables", {29'd0, addr_en, rd_en, wr_en}, 32'h0);
        check("rst_ad", {14'd0, AD}, {14'd0, HIZ});

        snap();
        mcu_addr(18'h00000);
        mcu_write(18'h01234);
        check("w_addr_pulse", addr_cnt - base_a, 1);
        check("w_cs", {28'd0, cs}, 32'h0);
        check("w_wr_pulse", wr_cnt - base_w, 1);
        check("w_rd_data", {16'd0, rd_data}, 32'h1234);
        check("w_same_cycle", {16'd0, wr_snap}, 32'h1234);

        wr_data = 32'h00FF_FF00;
        snap();
        mcu_addr(18'h00000);
        mcu_read(18'h3FF00, "r");
        check("r_rd_pulse", rd_cnt - base_r, 1);
        check("r_no_wr", wr_cnt - base_w, 0);

        snap();
        mcu_addr(18'h00005);
        mcu_write(18'h0BEEF);
        check("d_cs", {28'd0, cs}, 32'h5);
        check("d_rd_data", {16'd0, rd_data}, 32'hBEEF);
        wr_data = 32'h0000_2A5C;
        mcu_read(18'h02A5C, "d_read");
        check("d_cs_persist", {28'd0, cs}, 32'h5);
        check("d_pulses", (addr_cnt - base_a) * 100 + (rd_cnt - base_r) * 10 + (wr_cnt - base_w), 111);

        snap();
        mcu_addr(18'h2ABCD);
        check("d2_cs", {28'd0, cs}, 32'hD);

        snap();
        NOE = 1'b0;
        tick(6);
        NWE = 1'b0;
        tick(4);
        NWE = 1'b1;
        tick(4);
        NOE = 1'b1;
        tick(6);
        check("ign_no_wr", wr_cnt - base_w, 0);
        check("ign_rd_data", {16'd0, rd_data}, 32'hBEEF);
        check("ign_rd_pulse", rd_cnt - base_r, 1);

        wr_data = 32'h0001_0F0F;
        snap();
        NOE = 1'b0;
        tick(6);
        check("mr_driven", {14'd0, AD}, 32'h10F0F);
        reset_n = 1'b0;
        #1;
        check("mr_ad_hiz", {14'd0, AD}, {14'd0, HIZ});
        check("mr_cs", {28'd0, cs}, 32'h0);
        check("mr_rd_data", {16'd0, rd_data}, 32'h0);
        tick(2);
        NOE = 1'b1;
        tick(1);
        reset_n = 1'b1;
        tick(6);
        check("mr_no_rd_pulse", rd_cnt - base_r, 1);
        check("mr_ad_idle", {14'd0, AD}, {14'd0, HIZ});
        mcu_addr(18'h00003);
        mcu_write(18'h05A5A);
        check("mr_cs_after", {28'd0, cs}, 32'h3);
        check("mr_rd_data_after", {16'd0, rd_data}, 32'h5A5A);
        check("mr_wr_pulse", wr_cnt - base_w, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
